// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory master.
// Access sizes, FSM states, the word width in bytes, and the base lane mask per access size.
package lsu_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACC_LO  = 3'd1,
        ST_ACC_HI  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_ERR     = 3'd4
    } state_e;

    // Unshifted byte-lane mask for an access size. Encoding 3 maps to an
    // empty mask, and that empty mask is how the illegal size is detected.
    function automatic logic [3:0] size_base_mask(input logic [1:0] size);
        logic [3:0] mask;
        case (size)
            SZ_BYTE: mask = 4'b0001;
            SZ_HALF: mask = 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response handshake between the CPU memory stage and the LSU.
// The master side is the requester. The slave side is lsu_mem_master.
interface lsu_mem_master_if #(
    parameter int MEM_SIZE = 8192
);
    localparam int ADDR_W = $clog2(MEM_SIZE);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the LSU.
// Inputs: access size and byte offset.
// Outputs:
//   - low-word and high-word byte enables, and the split flag;
//   - write data shifted onto the byte lanes;
//   - the load result, taken from the {hi, lo} read pair and then
//     sign- or zero-extended.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic [3:0]  en_lo,
    output logic [3:0]  en_hi,
    output logic        split,
    output logic        illegal,
    output logic [31:0] wdata_lo,
    output logic [31:0] wdata_hi,
    output logic [31:0] rdata_ext
);

    logic [7:0]  mask_s;
    logic [63:0] wshift_s;
    logic [31:0] rshift_s;

    // Shift the lane mask and data by the byte offset, then extract and extend the load result.
    always_comb begin
        mask_s    = {4'b0000, size_base_mask(size)} << offset;
        wshift_s  = {32'h0000_0000, wdata} << {offset, 3'b000};
        rshift_s  = 32'({rdata_hi, rdata_lo} >> {offset, 3'b000});
        en_lo     = mask_s[3:0];
        en_hi     = mask_s[7:4];
        split     = |mask_s[7:4];
        illegal   = (size_base_mask(size) == 4'b0000);
        wdata_lo  = wshift_s[31:0];
        wdata_hi  = wshift_s[63:32];
        case (size)
            SZ_BYTE: rdata_ext = is_unsigned ? {24'h00_0000, rshift_s[7:0]}
                                             : {{24{rshift_s[7]}}, rshift_s[7:0]};
            SZ_HALF: rdata_ext = is_unsigned ? {16'h0000, rshift_s[15:0]}
                                             : {{16{rshift_s[15]}}, rshift_s[15:0]};
            SZ_WORD: rdata_ext = rshift_s;
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the data-side port of the word-addressed BRAM.
// Requests may use any byte address. The block turns each request into
// word-aligned accesses with byte enables, then realigns the returned read data.
// Optional feature: define LSU_MISALIGNED_SPLIT_EN to perform accesses that
// cross a word boundary as two accesses. Without it, such accesses are
// rejected with rsp_err.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter  int MEM_SIZE = 8192,
    localparam int ADDR_W   = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              reset,
    lsu_mem_master_if.slave   bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [3:0]        mem_data_en,
    output logic              mem_write_en
);

`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(WORD_BYTES);

    state_e            state_r;
    logic              req_ready_r;
    logic              req_we_r;
    logic [1:0]        req_size_r;
    logic              req_unsigned_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [31:0]       req_wdata_r;
    logic              rsp_valid_r;
    logic              rsp_err_r;
    logic [31:0]       rsp_rdata_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [3:0]        mem_en_r;
    logic              mem_we_r;

    logic [1:0]        sel_size_s;
    logic [1:0]        sel_off_s;
    logic              sel_unsigned_s;
    logic [31:0]       sel_wdata_s;
    logic [31:0]       rd_lo_s;
    logic [3:0]        en_lo_s;
    logic [3:0]        en_hi_s;
    logic              split_s;
    logic              illegal_s;
    logic [31:0]       wdata_lo_s;
    logic [31:0]       wdata_hi_s;
    logic [31:0]       rdata_ext_s;
    logic [ADDR_W-1:0] lo_addr_s;
    logic [ADDR_W-1:0] hi_addr_s;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic              split_r;
    logic [31:0]       lo_word_r;
`else
    logic              unused_hi_s;
    assign unused_hi_s = ^{en_hi_s, wdata_hi_s};
`endif

    assign bus.req_ready = req_ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_data_en   = mem_en_r;
    assign mem_write_en  = mem_we_r;

    assign lo_addr_s = {req_addr_r[ADDR_W-1:2], 2'b00};
    assign hi_addr_s = lo_addr_s + WORD_STEP;

    // In IDLE the aligner sees the live request so the first access can be set up at the accept edge.
    // In every other state it sees the captured copy of the request.
    always_comb begin
        if (state_r == ST_IDLE) begin
            sel_size_s     = bus.req_size;
            sel_off_s      = bus.req_addr[1:0];
            sel_unsigned_s = bus.req_unsigned;
            sel_wdata_s    = bus.req_wdata;
        end else begin
            sel_size_s     = req_size_r;
            sel_off_s      = req_addr_r[1:0];
            sel_unsigned_s = req_unsigned_r;
            sel_wdata_s    = req_wdata_r;
        end
        rd_lo_s = mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
        if (split_r) begin
            rd_lo_s = lo_word_r;
        end else begin
            rd_lo_s = mem_rdata;
        end
`endif
    end

    lsu_lane_align u_align (
        .size        (sel_size_s),
        .offset      (sel_off_s),
        .is_unsigned (sel_unsigned_s),
        .wdata       (sel_wdata_s),
        .rdata_lo    (rd_lo_s),
        .rdata_hi    (mem_rdata),
        .en_lo       (en_lo_s),
        .en_hi       (en_hi_s),
        .split       (split_s),
        .illegal     (illegal_s),
        .wdata_lo    (wdata_lo_s),
        .wdata_hi    (wdata_hi_s),
        .rdata_ext   (rdata_ext_s)
    );

    // Request FSM with registered memory-port and response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            req_ready_r    <= 1'b1;
            req_we_r       <= 1'b0;
            req_size_r     <= 2'b00;
            req_unsigned_r <= 1'b0;
            req_addr_r     <= '0;
            req_wdata_r    <= 32'h0000_0000;
            rsp_valid_r    <= 1'b0;
            rsp_err_r      <= 1'b0;
            rsp_rdata_r    <= 32'h0000_0000;
            mem_addr_r     <= '0;
            mem_wdata_r    <= 32'h0000_0000;
            mem_en_r       <= 4'b0000;
            mem_we_r       <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_r        <= 1'b0;
            lo_word_r      <= 32'h0000_0000;
`endif
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            mem_en_r    <= 4'b0000;
            mem_we_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        req_ready_r    <= 1'b0;
                        req_we_r       <= bus.req_we;
                        req_size_r     <= bus.req_size;
                        req_unsigned_r <= bus.req_unsigned;
                        req_addr_r     <= bus.req_addr;
                        req_wdata_r    <= bus.req_wdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
                        split_r        <= split_s;
`endif
                        if (illegal_s || (split_s && !SPLIT_EN)) begin
                            state_r <= ST_ERR;
                        end else begin
                            state_r     <= ST_ACC_LO;
                            mem_addr_r  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_r <= wdata_lo_s;
                            mem_en_r    <= en_lo_s;
                            mem_we_r    <= bus.req_we;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_ACC_LO: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    if (split_r) begin
                        state_r     <= ST_ACC_HI;
                        mem_addr_r  <= hi_addr_s;
                        mem_wdata_r <= wdata_hi_s;
                        mem_en_r    <= en_hi_s;
                        mem_we_r    <= req_we_r;
                    end else begin
                        state_r     <= ST_CAPTURE;
                    end
`else
                    state_r <= ST_CAPTURE;
`endif
                end
`ifdef LSU_MISALIGNED_SPLIT_EN
                ST_ACC_HI: begin
                    lo_word_r <= mem_rdata;
                    state_r   <= ST_CAPTURE;
                end
`endif
                ST_CAPTURE: begin
                    rsp_valid_r <= 1'b1;
                    rsp_rdata_r <= req_we_r ? 32'h0000_0000 : rdata_ext_s;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                ST_ERR: begin
                    rsp_valid_r <= 1'b1;
                    rsp_err_r   <= 1'b1;
                    rsp_rdata_r <= 32'h0000_0000;
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    req_ready_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed self-checking bench for lsu_mem_master. It contains a
// one-cycle-latency BRAM model with byte enables. Split-access expectations
// follow the LSU_MISALIGNED_SPLIT_EN macro.
module tb_lsu_mem_master;

    logic        clk;
    logic        reset;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  mem_data_en;
    logic        mem_write_en;

    int checks;
    int failures;

    logic [31:0] mem_q [0:2047];
    logic        bd_we;
    logic [10:0] bd_idx;
    logic [31:0] bd_data;

    logic [12:0] acc_addr [0:3];
    logic [3:0]  acc_en   [0:3];
    logic [31:0] acc_wd   [0:3];
    logic        acc_we   [0:3];

    lsu_mem_master_if #(.MEM_SIZE(8192)) bus ();

    lsu_mem_master #(.MEM_SIZE(8192)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.slave),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_data_en  (mem_data_en),
        .mem_write_en (mem_write_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: byte-enabled writes, registered read, plus a bench backdoor write.
    always @(posedge clk) begin
        if (bd_we) begin
            mem_q[bd_idx] <= bd_data;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (mem_write_en && mem_data_en[b]) mem_q[mem_addr[12:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        mem_rdata <= mem_q[mem_addr[12:2]];
    end

    task automatic poke(input logic [10:0] idx, input logic [31:0] data);
        bd_idx = idx; bd_data = data; bd_we = 1'b1;
        @(posedge clk); #1;
        bd_we = 1'b0;
    endtask

    // Issues one request from IDLE and records the memory accesses and the response.
    // It returns lat=0 if no response arrives.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [12:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er, output int nacc);
        lat = 0; rd = 32'h0; er = 1'b0; nacc = 0;
        bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (mem_data_en != 4'b0000 || mem_write_en) begin
                if (nacc < 4) begin
                    acc_addr[nacc] = mem_addr; acc_en[nacc] = mem_data_en;
                    acc_wd[nacc] = mem_wdata; acc_we[nacc] = mem_write_en;
                end
                nacc++;
            end
            if (bus.rsp_valid) begin
                lat = k; rd = bus.rsp_rdata; er = bus.rsp_err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks += 7;
        if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
        if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
        if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", bus.rsp_rdata); end
        if (mem_addr !== 13'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        if (mem_data_en !== 4'b0) begin failures++; $display("FAIL reset_mem_en got=%b exp=0000", mem_data_en); end
        if (mem_write_en !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%b exp=0", mem_write_en); end
    endtask

    task automatic test_store_word();
        int lat, n; logic [31:0] rd; logic er;
        do_req(1'b1, 2'd2, 1'b0, 13'h010, 32'hDEADBEEF, lat, rd, er, n);
        checks += 8;
        if (n !== 1) begin failures++; $display("FAIL sw_naccess got=%0d exp=1", n); end
        if (acc_addr[0] !== 13'h010) begin failures++; $display("FAIL sw_addr got=%h exp=010", acc_addr[0]); end
        if (acc_en[0] !== 4'b1111) begin failures++; $display("FAIL sw_en got=%b exp=1111", acc_en[0]); end
        if (acc_wd[0] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", acc_wd[0]); end
        if (acc_we[0] !== 1'b1) begin failures++; $display("FAIL sw_we got=%b exp=1", acc_we[0]); end
        if (lat !== 3) begin failures++; $display("FAIL sw_latency got=%0d exp=3", lat); end
        if (er !== 1'b0) begin failures++; $display("FAIL sw_err got=%b exp=0", er); end
        if (mem_q[4] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_mem got=%h exp=deadbeef", mem_q[4]); end
        @(posedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL sw_rsp_pulse got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_load_extend();
        int lat, n; logic [31:0] rd; logic er;
        poke(11'd4, 32'h80FF7F01);
        do_req(1'b0, 2'd0, 1'b0, 13'h013, 32'h0, lat, rd, er, n);
        checks += 5;
        if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_signed got=%h exp=ffffff80", rd); end
        if (lat !== 3) begin failures++; $display("FAIL lb_latency got=%0d exp=3", lat); end
        if (acc_en[0] !== 4'b1000) begin failures++; $display("FAIL lb_en got=%b exp=1000", acc_en[0]); end
        if (acc_we[0] !== 1'b0) begin failures++; $display("FAIL lb_we got=%b exp=0", acc_we[0]); end
        if (acc_addr[0] !== 13'h010) begin failures++; $display("FAIL lb_addr got=%h exp=010", acc_addr[0]); end
        do_req(1'b0, 2'd0, 1'b1, 13'h013, 32'h0, lat, rd, er, n);
        checks++;
        if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu got=%h exp=00000080", rd); end
        do_req(1'b0, 2'd1, 1'b1, 13'h012, 32'h0, lat, rd, er, n);
        checks += 2;
        if (rd !== 32'h000080FF) begin failures++; $display("FAIL lhu got=%h exp=000080ff", rd); end
        if (acc_en[0] !== 4'b1100) begin failures++; $display("FAIL lhu_en got=%b exp=1100", acc_en[0]); end
        do_req(1'b0, 2'd1, 1'b0, 13'h012, 32'h0, lat, rd, er, n);
        checks++;
        if (rd !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_signed got=%h exp=ffff80ff", rd); end
        do_req(1'b0, 2'd0, 1'b0, 13'h011, 32'h0, lat, rd, er, n);
        checks++;
        if (rd !== 32'h0000007F) begin failures++; $display("FAIL lb_pos got=%h exp=0000007f", rd); end
        do_req(1'b0, 2'd2, 1'b0, 13'h010, 32'h0, lat, rd, er, n);
        checks++;
        if (rd !== 32'h80FF7F01) begin failures++; $display("FAIL lw got=%h exp=80ff7f01", rd); end
    endtask

    task automatic test_store_narrow();
        int lat, n; logic [31:0] rd; logic er;
        poke(11'd5, 32'h00000000);
        do_req(1'b1, 2'd0, 1'b0, 13'h015, 32'h1234565A, lat, rd, er, n);
        checks += 3;
        if (acc_en[0] !== 4'b0010) begin failures++; $display("FAIL sb_en got=%b exp=0010", acc_en[0]); end
        if (acc_wd[0] !== 32'h34565A00) begin failures++; $display("FAIL sb_wdata got=%h exp=34565a00", acc_wd[0]); end
        if (rd !== 32'h0) begin failures++; $display("FAIL sb_rdata got=%h exp=0", rd); end
        do_req(1'b1, 2'd1, 1'b0, 13'h016, 32'h0000BEEF, lat, rd, er, n);
        checks += 3;
        if (acc_en[0] !== 4'b1100) begin failures++; $display("FAIL sh_en got=%b exp=1100", acc_en[0]); end
        if (acc_wd[0] !== 32'hBEEF0000) begin failures++; $display("FAIL sh_wdata got=%h exp=beef0000", acc_wd[0]); end
        if (mem_q[5] !== 32'hBEEF5A00) begin failures++; $display("FAIL sh_mem got=%h exp=beef5a00", mem_q[5]); end
    endtask

    task automatic test_split();
        int lat, n; logic [31:0] rd; logic er;
        poke(11'd4, 32'h44332211);
        poke(11'd5, 32'h88776655);
        poke(11'd2047, 32'h00000000);
        poke(11'd0, 32'h00000000);
        do_req(1'b0, 2'd2, 1'b0, 13'h013, 32'h0, lat, rd, er, n);
`ifdef LSU_MISALIGNED_SPLIT_EN
        checks += 8;
        if (n !== 2) begin failures++; $display("FAIL split_lw_naccess got=%0d exp=2", n); end
        if (acc_addr[0] !== 13'h010 || acc_en[0] !== 4'b1000) begin failures++; $display("FAIL split_lw_lo got=%h/%b exp=010/1000", acc_addr[0], acc_en[0]); end
        if (acc_addr[1] !== 13'h014 || acc_en[1] !== 4'b0111) begin failures++; $display("FAIL split_lw_hi got=%h/%b exp=014/0111", acc_addr[1], acc_en[1]); end
        if (rd !== 32'h77665544) begin failures++; $display("FAIL split_lw_rdata got=%h exp=77665544", rd); end
        if (lat !== 4) begin failures++; $display("FAIL split_lw_latency got=%0d exp=4", lat); end
        if (er !== 1'b0) begin failures++; $display("FAIL split_lw_err got=%b exp=0", er); end
        if (acc_we[0] !== 1'b0) begin failures++; $display("FAIL split_lw_we got=%b exp=0", acc_we[0]); end
        if (acc_we[1] !== 1'b0) begin failures++; $display("FAIL split_lw_we_hi got=%b exp=0", acc_we[1]); end
        do_req(1'b1, 2'd1, 1'b0, 13'h1FFF, 32'h0000BBAA, lat, rd, er, n);
        checks += 6;
        if (acc_addr[0] !== 13'h1FFC || acc_en[0] !== 4'b1000) begin failures++; $display("FAIL split_sh_lo got=%h/%b exp=1ffc/1000", acc_addr[0], acc_en[0]); end
        if (acc_addr[1] !== 13'h0000 || acc_en[1] !== 4'b0001) begin failures++; $display("FAIL split_sh_hi got=%h/%b exp=0000/0001", acc_addr[1], acc_en[1]); end
        if (acc_wd[0] !== 32'hAA000000 || acc_wd[1] !== 32'h000000BB) begin failures++; $display("FAIL split_sh_wdata got=%h/%h exp=aa000000/000000bb", acc_wd[0], acc_wd[1]); end
        if (mem_q[2047] !== 32'hAA000000) begin failures++; $display("FAIL split_sh_mem_lo got=%h exp=aa000000", mem_q[2047]); end
        if (mem_q[0] !== 32'h000000BB) begin failures++; $display("FAIL split_sh_mem_hi got=%h exp=000000bb", mem_q[0]); end
        if (lat !== 4) begin failures++; $display("FAIL split_sh_latency got=%0d exp=4", lat); end
`else
        checks += 4;
        if (er !== 1'b1) begin failures++; $display("FAIL nosplit_lw_err got=%b exp=1", er); end
        if (rd !== 32'h0) begin failures++; $display("FAIL nosplit_lw_rdata got=%h exp=0", rd); end
        if (lat !== 2) begin failures++; $display("FAIL nosplit_lw_latency got=%0d exp=2", lat); end
        if (n !== 0) begin failures++; $display("FAIL nosplit_lw_naccess got=%0d exp=0", n); end
        do_req(1'b1, 2'd1, 1'b0, 13'h1FFF, 32'h0000BBAA, lat, rd, er, n);
        checks += 3;
        if (er !== 1'b1 || lat !== 2) begin failures++; $display("FAIL nosplit_sh_err got=%b/%0d exp=1/2", er, lat); end
        if (n !== 0) begin failures++; $display("FAIL nosplit_sh_naccess got=%0d exp=0", n); end
        if (mem_q[2047] !== 32'h0 || mem_q[0] !== 32'h0) begin failures++; $display("FAIL nosplit_sh_mem got=%h/%h exp=0/0", mem_q[2047], mem_q[0]); end
`endif
    endtask

    task automatic test_illegal();
        int lat, n; logic [31:0] rd; logic er;
        do_req(1'b0, 2'd2, 1'b0, 13'h010, 32'h0, lat, rd, er, n);
        checks++;
        if (rd !== 32'h44332211) begin failures++; $display("FAIL ill_pre_rdata got=%h exp=44332211", rd); end
        do_req(1'b0, 2'd3, 1'b0, 13'h010, 32'h0, lat, rd, er, n);
        checks += 4;
        if (er !== 1'b1) begin failures++; $display("FAIL ill_err got=%b exp=1", er); end
        if (rd !== 32'h0) begin failures++; $display("FAIL ill_rdata got=%h exp=0", rd); end
        if (lat !== 2) begin failures++; $display("FAIL ill_latency got=%0d exp=2", lat); end
        if (n !== 0) begin failures++; $display("FAIL ill_naccess got=%0d exp=0", n); end
        do_req(1'b1, 2'd3, 1'b0, 13'h010, 32'hFFFFFFFF, lat, rd, er, n);
        checks += 2;
        if (er !== 1'b1 || n !== 0) begin failures++; $display("FAIL ill_store got=%b/%0d exp=1/0", er, n); end
        if (mem_q[4] !== 32'h44332211) begin failures++; $display("FAIL ill_store_mem got=%h exp=44332211", mem_q[4]); end
        @(posedge clk); #1;
        checks++;
        if (bus.rsp_err !== 1'b0) begin failures++; $display("FAIL ill_err_pulse got=%b exp=0", bus.rsp_err); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] mask;
        logic [31:0] r1;
        logic acc;
        mask = 9'h0; r1 = 32'h0;
        poke(11'd8, 32'hCAFEF00D);
        poke(11'd9, 32'h00000000);
        bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = 13'h020; bus.req_wdata = 32'h0; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_we = 1'b1; bus.req_addr = 13'h024; bus.req_wdata = 32'h13579BDF;
        for (int k = 1; k <= 8; k++) begin
            if (bus.rsp_valid) begin
                mask[k] = 1'b1;
                if (k == 3) r1 = bus.rsp_rdata;
            end
            acc = bus.req_valid && bus.req_ready;
            @(posedge clk); #1;
            if (acc) bus.req_valid = 1'b0;
        end
        bus.req_valid = 1'b0;
        checks += 3;
        if (mask !== 9'h048) begin failures++; $display("FAIL b2b_rsp_cycles got=%b exp=001001000", mask); end
        if (r1 !== 32'hCAFEF00D) begin failures++; $display("FAIL b2b_rdata got=%h exp=cafef00d", r1); end
        if (mem_q[9] !== 32'h13579BDF) begin failures++; $display("FAIL b2b_mem got=%h exp=13579bdf", mem_q[9]); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        // Aligned store, with reset sampled on the edge that ends ACC_LO.
        poke(11'd2, 32'h00000000);
        bus.req_we = 1'b1; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = 13'h008; bus.req_wdata = 32'h11223344; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        checks += 2;
        if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_lo_ready got=%b exp=1", bus.req_ready); end
        if (mem_data_en !== 4'b0 || mem_write_en !== 1'b0) begin failures++; $display("FAIL rst_lo_idle_bus got=%b/%b exp=0000/0", mem_data_en, mem_write_en); end
        repeat (5) begin if (bus.rsp_valid) seen = 1'b1; @(posedge clk); #1; end
        checks += 2;
        if (seen !== 1'b0) begin failures++; $display("FAIL rst_lo_no_rsp got=%b exp=0", seen); end
        if (mem_q[2] !== 32'h11223344) begin failures++; $display("FAIL rst_lo_mem got=%h exp=11223344", mem_q[2]); end
`ifdef LSU_MISALIGNED_SPLIT_EN
        // Split store, with reset sampled on the edge that ends ACC_HI.
        poke(11'd0, 32'h0); poke(11'd1, 32'h0);
        bus.req_addr = 13'h001; bus.req_wdata = 32'hAABBCCDD; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        checks++;
        if (mem_data_en !== 4'b1110 || mem_wdata !== 32'hBBCCDD00) begin failures++; $display("FAIL rst_hi_lo_acc got=%b/%h exp=1110/bbccdd00", mem_data_en, mem_wdata); end
        @(posedge clk); #1;
        checks++;
        if (mem_addr !== 13'h004 || mem_data_en !== 4'b0001 || mem_wdata !== 32'h000000AA) begin failures++; $display("FAIL rst_hi_hi_acc got=%h/%b/%h exp=004/0001/000000aa", mem_addr, mem_data_en, mem_wdata); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_hi_ready got=%b exp=1", bus.req_ready); end
        repeat (5) begin if (bus.rsp_valid) seen = 1'b1; @(posedge clk); #1; end
        checks += 3;
        if (seen !== 1'b0) begin failures++; $display("FAIL rst_hi_no_rsp got=%b exp=0", seen); end
        if (mem_q[0] !== 32'hBBCCDD00) begin failures++; $display("FAIL rst_hi_mem_lo got=%h exp=bbccdd00", mem_q[0]); end
        if (mem_q[1] !== 32'h000000AA) begin failures++; $display("FAIL rst_hi_mem_hi got=%h exp=000000aa", mem_q[1]); end
        // Split store, with reset sampled on the edge that ends ACC_LO.
        poke(11'd0, 32'h0); poke(11'd1, 32'h0);
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks += 2;
        if (mem_q[0] !== 32'hBBCCDD00) begin failures++; $display("FAIL rst_lo_split_mem_lo got=%h exp=bbccdd00", mem_q[0]); end
        if (mem_q[1] !== 32'h00000000) begin failures++; $display("FAIL rst_lo_split_mem_hi got=%h exp=00000000", mem_q[1]); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        bd_we = 1'b0; bd_idx = 11'd0; bd_data = 32'h0;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 13'h0; bus.req_wdata = 32'h0;
        test_reset();
        test_store_word();
        test_load_extend();
        test_store_narrow();
        test_split();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
